// File: rtl/max_pool_ctrl.sv
// max_pool_ctrl: 2x2 stride-2 signed max-pool sequencer, conv BRAM (port B) -> pool BRAM (port A)
// Ports: clk/rst_n clock and async active-low reset; start launches a pool of all channels,
// busy/done report progress; src_* read the conv map (byte addr, data 1 cycle after src_en);
// dst_* write pooled words (byte addr, dst_we=4'hF on write).
module max_pool_ctrl #(
  parameter int IN_W = 26,
  parameter int IN_H = 26,
  parameter int CHANNELS = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       src_addr,
  output logic              src_en,
  input  logic [DATA_W-1:0] src_dout,
  output logic [31:0]       dst_addr,
  output logic [DATA_W-1:0] dst_din,
  output logic              dst_en,
  output logic [3:0]        dst_we
);
  localparam logic [31:0] OW = 32'(IN_W / 2);
  localparam logic [31:0] OH = 32'(IN_H / 2);
  localparam logic [31:0] CH = 32'(CHANNELS);
  localparam logic [31:0] IW = 32'(IN_W);
  localparam logic [31:0] IPL = 32'(IN_W * IN_H);
  localparam logic [31:0] OPL = OW * OH;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LAST = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [1:0] k;
  logic [31:0] x, r, c;
  logic signed [DATA_W-1:0] mx;
  logic xl, rl, cl, first;
  assign xl = x == OW - 1;
  assign rl = r == OH - 1;
  assign cl = c == CH - 1;
  assign busy = state == FETCH || state == LAST || state == WRITE;
  assign done = state == DONE;
  assign src_en = state == FETCH;
  assign dst_en = state == WRITE;
  assign dst_we = dst_en ? 4'hF : 4'h0;
  assign dst_din = mx;
  // k selects (dy,dx) = (k[1],k[0]) within the window
  assign src_addr = (c * IPL + ((r << 1) + 32'(k[1])) * IW + (x << 1) + 32'(k[0])) << 2;
  assign dst_addr = (c * OPL + r * OW + x) << 2;
  // read data lags src_en by one cycle: word k arrives while FETCH k+1 (or LAST for k=3)
  assign first = state == FETCH && k == 2'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mx <= '0;
    else if ((state == FETCH && k != 2'd0) || state == LAST)
      mx <= (first || $signed(src_dout) > mx) ? src_dout : mx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      x <= '0;
      r <= '0;
      c <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          k <= '0;
          x <= '0;
          r <= '0;
          c <= '0;
        end
        FETCH: begin
          k <= k + 2'd1;
          if (k == 2'd3) state <= LAST;
        end
        LAST: state <= WRITE;
        WRITE: begin
          x <= xl ? '0 : x + 1;
          r <= xl ? (rl ? '0 : r + 1) : r;
          c <= (xl && rl) ? (cl ? '0 : c + 1) : c;
          state <= (xl && rl && cl) ? DONE : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_max_pool_ctrl.sv
// tb_max_pool_ctrl: three configurations (4x4x1, 5x5x2, 26x26x8) checked every cycle against a window-max model
module tb_max_pool_ctrl;
  localparam int PW[3] = '{4, 5, 26};
  localparam int PC[3] = '{1, 2, 8};
  localparam int NW[3] = '{4, 8, 1352};
  localparam int TD[3] = '{25, 49, 8113};
  localparam int MS = 5408;
  logic clk;
  logic rst_n[3], start[3], busy[3], done[3], src_en[3], dst_en[3];
  logic [31:0] src_addr[3], dst_addr[3], src_dout[3], dst_din[3];
  logic [3:0] dst_we[3];
  logic [31:0] mem[3][MS];
  logic [31:0] ew[3][1352];
  logic [31:0] lit[2][4] = '{'{5, 7, 13, 15}, '{32'hFFFFFFFF, 32'h7FFFFFFF, 5, 32'hFFFFFFFB}};
  logic [31:0] sv[16] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                          32'hFFFFFFF9, 32'hFFFFFFFE, 0, 1,
                          5, 5, 32'hFFFFFFF8, 32'hFFFFFFFB,
                          5, 5, 32'hFFFFFFFB, 32'hFFFFFFFA};
  int nchk = 0, nfail = 0, mode = 0;
  int cyc[3], wp[3];
  bit act[3];
  for (genvar g = 0; g < 3; g++) begin : u
    max_pool_ctrl #(.IN_W(PW[g]), .IN_H(PW[g]), .CHANNELS(PC[g]), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n[g]), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .src_addr(src_addr[g]), .src_en(src_en[g]), .src_dout(src_dout[g]),
      .dst_addr(dst_addr[g]), .dst_din(dst_din[g]), .dst_en(dst_en[g]), .dst_we(dst_we[g]));
  end
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (src_en[i]) src_dout[i] <= (src_addr[i] >> 2) < MS ? mem[i][src_addr[i] >> 2] : 32'h0;
  function automatic int widx(input int i, input int j, input int p);
    int ow = PW[i] / 2;
    int c = j / (ow * ow);
    int m = j % (ow * ow);
    return c * PW[i] * PW[i] + (2 * (m / ow) + p / 2) * PW[i] + 2 * (m % ow) + p % 2;
  endfunction
  task automatic build(input int i);
    for (int j = 0; j < NW[i]; j++) begin
      logic [31:0] m = mem[i][widx(i, j, 0)];
      for (int p = 1; p < 4; p++)
        if ($signed(mem[i][widx(i, j, p)]) > $signed(m)) m = mem[i][widx(i, j, p)];
      ew[i][j] = m;
    end
  endtask
  task automatic chk(input string s, input int i, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s[%0d] cyc=%0d: got %h expected %h", s, i, cyc[i], a, e);
    end
  endtask
  always @(negedge clk) begin
    int t, j, p;
    bit on, acc;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        act[i] = 0;
        chk("rst_busy", i, 32'(busy[i]), 0);
        chk("rst_done", i, 32'(done[i]), 0);
        chk("rst_src_en", i, 32'(src_en[i]), 0);
        chk("rst_dst_en", i, 32'(dst_en[i]), 0);
        chk("rst_dst_we", i, 32'(dst_we[i]), 0);
        chk("rst_src_addr", i, src_addr[i], 0);
        chk("rst_dst_addr", i, dst_addr[i], 0);
        chk("rst_dst_din", i, dst_din[i], 0);
      end else begin
        if (act[i]) cyc[i]++;
        t = cyc[i];
        on = act[i] && t >= 1 && t <= 6 * NW[i];
        j = (t - 1) / 6;
        p = (t - 1) % 6;
        if (dst_en[i]) wp[i]++;
        chk("busy", i, 32'(busy[i]), 32'(on));
        chk("done", i, 32'(done[i]), 32'(act[i] && t == TD[i]));
        chk("src_en", i, 32'(src_en[i]), 32'(on && p < 4));
        chk("dst_en", i, 32'(dst_en[i]), 32'(on && p == 5));
        chk("dst_we", i, 32'(dst_we[i]), (on && p == 5) ? 32'hF : 32'h0);
        if (on && p < 4) chk("src_addr", i, src_addr[i], 32'(widx(i, j, p) * 4));
        if (i == 1 && on && j == 4 && p == 0) chk("ch1_src_addr", i, src_addr[i], 100);
        if (on && p == 5) begin
          chk("dst_addr", i, dst_addr[i], 32'(j * 4));
          chk("dst_din", i, dst_din[i], ew[i][j]);
          if (i == 0) chk("lit_din", i, dst_din[i], lit[mode][j]);
          if (i == 1 && j == 4) chk("ch1_dst_addr", i, dst_addr[i], 16);
        end
        acc = !act[i] && start[i];
        if (act[i] && t == TD[i]) begin
          chk("nwrites", i, 32'(wp[i]), 32'(NW[i]));
          act[i] = 0;
        end
        if (acc) begin
          act[i] = 1;
          cyc[i] = 0;
          wp[i] = 0;
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 0;
      start[i] = 0;
      act[i] = 0;
      cyc[i] = 0;
      wp[i] = 0;
    end
    for (int a = 0; a < MS; a++) begin
      mem[0][a] = a < 16 ? 32'(a) : 32'h0;
      mem[1][a] = $urandom;
      mem[2][a] = $urandom;
    end
    for (int i = 0; i < 3; i++) build(i);
    tick(3);
    for (int i = 0; i < 3; i++) rst_n[i] = 1;
    tick(2);
    for (int i = 0; i < 3; i++) start[i] = 1;
    tick(1);
    for (int i = 0; i < 3; i++) start[i] = 0;
    tick(60);
    for (int a = 0; a < 16; a++) mem[0][a] = sv[a];
    mode = 1;
    build(0);
    start[0] = 1;
    tick(1);
    start[0] = 0;
    tick(37);
    start[2] = 1;
    tick(1);
    start[2] = 0;
    tick(200);
    rst_n[2] = 0;
    tick(3);
    rst_n[2] = 1;
    tick(10);
    start[2] = 1;
    tick(1);
    start[2] = 0;
    tick(8130);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/max_pool_ctrl.md
Name: max_pool_ctrl

Overview:
- Sequencer for the first 2x2/stride-2 max-pool stage of the MNIST CNN accelerator.
- Reads conv-1 feature maps from the conv output BRAM (port B side) and computes the signed maximum of each 2x2 window.
- Writes each result into the max-pool output BRAM through its port A.
- Started by the RISC-V CNN control logic; reports busy/done.

Parameters:
IN_W, 26, input feature-map width (pixels)
IN_H, 26, input feature-map height (pixels)
CHANNELS, 8, number of feature maps processed per start
DATA_W, 32, pixel word width, signed two's complement

Ports:
clk  input  1  single system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to pool all channels
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last write completes
src_addr  output  32  byte address into conv output BRAM (word index << 2)
src_en  output  1  read enable to conv output BRAM
src_dout  input  DATA_W  read data from conv output BRAM, valid 1 cycle after src_en
dst_addr  output  32  byte address into max-pool output BRAM port A (word index << 2)
dst_din  output  DATA_W  pooled value
dst_en  output  1  port-A enable
dst_we  output  4  port-A byte write enables; 4'hF on write, else 4'h0

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, src_en=0, dst_en=0, dst_we=0; src_addr, dst_addr, dst_din = 0; all counters = 0. Deasserting reset mid-operation leaves the block in IDLE. The partial output is abandoned and no done pulse is produced.
- OUT_W = IN_W/2 and OUT_H = IN_H/2, integer floor. For odd dimensions the last column/row is ignored.
- Loop order: channel c (outer), output row r, output column x (inner).
- Source word index = c*IN_H*IN_W + (2r+dy)*IN_W + (2x+dx).
- Destination word index = c*OUT_H*OUT_W + r*OUT_W + x.
- FSM states:
  - IDLE: start=1 goes to FETCH, zeroes counters and sets busy=1 next cycle. A start while busy is ignored.
  - FETCH: four consecutive cycles with k=0..3 and src_en=1. (dy,dx) per k is (0,0), (0,1), (1,0), (1,1). After k=3, go to LAST.
  - LAST: src_en=0; captures the 4th data word. Go to WRITE.
  - WRITE: dst_en=1, dst_we=4'hF, dst_din=max, dst_addr per the formula. Advance x, then r, then c. If the last window of the last channel was just written, go to DONE; otherwise go to FETCH.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Max datapath:
  - The data returning for k=0 loads max directly.
  - Each later word replaces max only if strictly greater (signed compare). Ties keep the earlier value.
  - No saturation or rescaling; dst_din = max bit-exact.
- Timing:
  - Each output takes exactly 6 cycles (FETCH x4, LAST, WRITE).
  - Total from accepted start to the done pulse = 6*CHANNELS*OUT_H*OUT_W + 1 cycles.
  - Default configuration: 6*8*13*13 + 1 = 8113 cycles.
- dst_en and dst_we are high only in WRITE. src_en is high only in FETCH. The two BRAMs are never accessed in the same cycle.
- start coincident with DONE is ignored. start is re-sampled only in IDLE.

Test Plan:
- Single channel (CHANNELS=1, IN_W=IN_H=4), src holds 0..15 -> writes 4 words: idx0=5, idx1=7, idx2=13, idx3=15 at byte addrs 0, 4, 8, 12; done occurs 25 cycles after start.
- Signed values: window {-3, -1, -7, -2} -> dst_din=0xFFFFFFFF (-1). Window {0x80000000, 0x7FFFFFFF, 0, 1} -> 0x7FFFFFFF.
- Odd size IN_W=IN_H=5, CHANNELS=2 -> 8 writes total. Row/column 4 addresses are never read. Channel-1 first source byte addr = 25*4 = 100; its first dst byte addr = 16.
- Full default run with random src -> 1352 writes, each matching a golden model; done pulse at cycle 8113 after start; busy high throughout.
- start pulsed again at cycle 100 of a run -> ignored: no restart, same write sequence, single done pulse.
- rst_n dropped mid-run at write 50 -> all outputs 0 immediately; after release no further accesses until a new start, which then completes normally from index 0.
